// File: rtl/zigbee_pkg.sv
// Shared constants and types for the zigbee symbol path.
package zigbee_pkg;

    localparam int SYM_W  = 4;
    localparam int WORD_W = 16;
    localparam int N_SYM  = 4;

    typedef logic [SYM_W-1:0]         sym_t;
    typedef logic [WORD_W-1:0]        word_t;
    typedef logic [$clog2(N_SYM)-1:0] sel_t;

    // One buffered word: symbols, symbol count minus one, frame-end tag.
    typedef struct packed {
        word_t word;
        sel_t  cnt;
        logic  last;
    } slot_t;

endpackage

// File: rtl/MUX414.sv
// 4:1 mux of 4-bit nibbles. din = {word[15:0], sel[1:0]};
// select 0 picks the most significant nibble, select 3 the least.
module MUX414 (
    input  logic [17:0] din,
    output logic [3:0]  dout
);

    // Nibble selection from the low two bits of din.
    always_comb begin
        // NOTE: default first so every path assigns dout and no latch is inferred.
        dout = din[17:14];
        case (din[1:0])
            2'd0: dout = din[17:14];
            2'd1: dout = din[13:10];
            2'd2: dout = din[9:6];
            2'd3: dout = din[5:2];
            default: dout = din[17:14];
        endcase
    end

endmodule

// File: rtl/symbol_sequencer.sv
// Splits 16-bit words of four zigbee symbols into a symbol stream.
// An active slot feeds the mux; a one-deep pending slot lets the next word
// wait so consecutive words stream without a bubble.
module symbol_sequencer
    import zigbee_pkg::*;
(
    input  logic        inClk,
    input  logic        inRst,
    input  logic        inWordValid,
    output logic        outWordReady,
    input  logic [15:0] inWord,
    input  logic [1:0]  inWordCnt,
    input  logic        inWordLast,
    output logic        outSymValid,
    input  logic        inSymReady,
    output logic [3:0]  outSym,
    output logic        outSymLast,
    output logic        outBusy
);

    logic  act_valid;
    logic  pend_valid;
    slot_t act;
    slot_t pend;
    sel_t  sel;

    slot_t in_slot;
    logic  word_xfer;
    logic  sym_xfer;
    logic  at_end;
    logic  fin;

    assign in_slot   = '{word: inWord, cnt: inWordCnt, last: inWordLast};
    assign word_xfer = inWordValid & outWordReady;
    assign sym_xfer  = act_valid & inSymReady;
    assign at_end    = (sel == act.cnt);
    assign fin       = sym_xfer & at_end;

    // Active/pending slot loading and symbol select counter.
    always_ff @(posedge inClk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (inRst) begin
            act_valid  <= 1'b0;
            pend_valid <= 1'b0;
            act        <= '0;
            pend       <= '0;
            sel        <= '0;
        end else if (!act_valid || (fin && !pend_valid)) begin
            // Active slot is free (or frees now): an accepted word goes straight in.
            act_valid <= word_xfer;
            if (word_xfer) begin
                act <= in_slot;
            end
            sel <= '0;
        end else if (fin) begin
            // Active word finishes with a word waiting: promote it, no bubble.
            act        <= pend;
            pend_valid <= 1'b0;
            sel        <= '0;
        end else begin
            // Active word still sending: park any accepted word and advance.
            if (word_xfer) begin
                pend_valid <= 1'b1;
                pend       <= in_slot;
            end
            if (sym_xfer) begin
                sel <= sel + 1'b1;
            end
        end
    end

    MUX414 u_mux (
        .din  ({act.word, sel}),
        .dout (outSym)
    );

    // Ready depends on registered state only, so upstream never sees inSymReady.
    assign outWordReady = !pend_valid;
    assign outSymValid  = act_valid;
    assign outSymLast   = act_valid & act.last & at_end;
    assign outBusy      = act_valid | pend_valid;

endmodule

// File: tb/tb_symbol_sequencer.sv
// Self-checking bench for symbol_sequencer: table of words with hand-derived
// expected symbol sequences, scoreboard of expected symbols, negedge monitor.
module tb_symbol_sequencer;

    logic        inClk;
    logic        inRst;
    logic        inWordValid;
    logic        outWordReady;
    logic [15:0] inWord;
    logic [1:0]  inWordCnt;
    logic        inWordLast;
    logic        outSymValid;
    logic        inSymReady;
    logic [3:0]  outSym;
    logic        outSymLast;
    logic        outBusy;

    symbol_sequencer dut (
        .inClk        (inClk),
        .inRst        (inRst),
        .inWordValid  (inWordValid),
        .outWordReady (outWordReady),
        .inWord       (inWord),
        .inWordCnt    (inWordCnt),
        .inWordLast   (inWordLast),
        .outSymValid  (outSymValid),
        .inSymReady   (inSymReady),
        .outSym       (outSym),
        .outSymLast   (outSymLast),
        .outBusy      (outBusy)
    );

    typedef struct {
        logic [15:0] word;
        logic [1:0]  cnt;
        logic        last;
        logic [15:0] exp_seq;   // expected symbols, first in [15:12]
        int          exp_n;
    } vec_t;

    typedef struct packed {
        logic [3:0] sym;
        logic       last;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_acc = -1;
    int last_xfer_cyc = 0;
    logic sel_zero_chk = 1'b0;
    logic prev_stall = 1'b0;
    logic [3:0] prev_sym = '0;
    logic prev_last = 1'b0;

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    always @(posedge inClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: score every symbol transfer and verify holds during stalls.
    always @(negedge inClk) begin
        exp_t e;
        if (inRst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", {31'd0, outSymValid}, 32'd1);
                check("stall_hold_sym", {28'd0, outSym}, {28'd0, prev_sym});
                check("stall_hold_last", {31'd0, outSymLast}, {31'd0, prev_last});
            end
            if (sel_zero_chk)
                check("sel_zero", {30'd0, dut.sel}, 32'd0);
            if (outSymValid && inSymReady) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sym actual=%0h required=none", outSym);
                end else begin
                    e = sb.pop_front();
                    check("sym", {28'd0, outSym}, {28'd0, e.sym});
                    check("sym_last", {31'd0, outSymLast}, {31'd0, e.last});
                end
                last_xfer_cyc = cyc;
            end
            prev_stall = outSymValid && !inSymReady;
            prev_sym   = outSym;
            prev_last  = outSymLast;
        end
    end

    // Drive one table word, push its expected symbols on acceptance.
    task automatic send_word(input int idx);
        logic        accepted;
        logic [15:0] seq;
        exp_t        e;
        accepted    = 1'b0;
        inWord      = vecs[idx].word;
        inWordCnt   = vecs[idx].cnt;
        inWordLast  = vecs[idx].last;
        inWordValid = 1'b1;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge inClk);
            if (outWordReady) begin
                accepted = 1'b1;
                if (first_acc < 0) first_acc = cyc;
                seq = vecs[idx].exp_seq;
                for (int k = 0; k < vecs[idx].exp_n; k++) begin
                    e.sym  = seq[15:12];
                    e.last = vecs[idx].last && (k == vecs[idx].exp_n - 1);
                    sb.push_back(e);
                    seq = seq << 4;
                end
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL word_accept_timeout actual=not_ready required=ready");
        end
        @(posedge inClk);
        #1;
        inWordValid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge inClk);
            #1;
            t++;
        end
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        logic [6:0] pat;
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] pat;
        vecs[0] = '{16'hA5C3, 2'd3, 1'b0, 16'hA5C3, 4};
        vecs[1] = '{16'h1234, 2'd3, 1'b0, 16'h1234, 4};
        vecs[2] = '{16'h5678, 2'd3, 1'b1, 16'h5678, 4};
        vecs[3] = '{16'hBEEF, 2'd1, 1'b1, 16'hBE00, 2};
        vecs[4] = '{16'h9ABC, 2'd3, 1'b0, 16'h9ABC, 4};
        vecs[5] = '{16'h0F0F, 2'd3, 1'b0, 16'h0F0F, 4};
        vecs[6] = '{16'h1000, 2'd0, 1'b0, 16'h1000, 1};
        vecs[7] = '{16'h2000, 2'd0, 1'b0, 16'h2000, 1};
        vecs[8] = '{16'h3000, 2'd0, 1'b0, 16'h3000, 1};
        vecs[9] = '{16'h4000, 2'd0, 1'b0, 16'h4000, 1};

        inRst = 1'b1;
        inWordValid = 1'b0;
        inWord = '0;
        inWordCnt = '0;
        inWordLast = 1'b0;
        inSymReady = 1'b1;
        repeat (2) @(posedge inClk);
        #1;
        inRst = 1'b0;
        check("rst_sym_valid", {31'd0, outSymValid}, 32'd0);
        check("rst_sym", {28'd0, outSym}, 32'd0);
        check("rst_sym_last", {31'd0, outSymLast}, 32'd0);
        check("rst_busy", {31'd0, outBusy}, 32'd0);
        check("rst_word_ready", {31'd0, outWordReady}, 32'd1);

        // Single full word, sink always ready.
        first_acc = -1;
        send_word(0);
        drain();
        check("t1_span", last_xfer_cyc - first_acc, 32'd4);

        // Two words back to back; pending fills and blocks upstream.
        first_acc = -1;
        for (int i = 1; i <= 2; i++) begin
            send_word(i);
            if (i == 2) begin
                check("t2_ready_low", {31'd0, outWordReady}, 32'd0);
                check("t2_busy", {31'd0, outBusy}, 32'd1);
            end
        end
        drain();
        check("t2_span", last_xfer_cyc - first_acc, 32'd8);

        // Downstream stalls: pattern 1,0,0,1,0,1,1.
        send_word(0);
        pat = 7'b1001011;
        for (int i = 6; i >= 0; i--) begin
            inSymReady = pat[i];
            @(posedge inClk);
            #1;
        end
        inSymReady = 1'b1;
        check("t3_all_sent", sb.size(), 32'd0);
        check("t3_idle", {31'd0, outBusy}, 32'd0);

        // Partial word tagged last.
        send_word(3);
        drain();
        check("t4_idle_after", {31'd0, outBusy}, 32'd0);

        // Reset mid-operation drops active and pending words.
        send_word(4);
        send_word(5);
        @(posedge inClk);
        #1;
        check("t5_pend_full", {31'd0, outWordReady}, 32'd0);
        inSymReady = 1'b0;
        inRst = 1'b1;
        @(posedge inClk);
        #1;
        inRst = 1'b0;
        check("t5_rst_valid", {31'd0, outSymValid}, 32'd0);
        check("t5_rst_busy", {31'd0, outBusy}, 32'd0);
        check("t5_rst_ready", {31'd0, outWordReady}, 32'd1);
        sb.delete();
        inSymReady = 1'b1;
        send_word(5);
        drain();

        // Single-symbol words stream without gaps; select never leaves 0.
        first_acc = -1;
        sel_zero_chk = 1'b1;
        for (int i = 6; i <= 9; i++) send_word(i);
        drain();
        sel_zero_chk = 1'b0;
        check("t6_span", last_xfer_cyc - first_acc, 32'd4);

        repeat (2) @(posedge inClk);
        #1;
        check("end_idle", {31'd0, outBusy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
